// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter and colour types for the sync generator
// and its optional colour-bar source.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned BAR_WIDTH = 80;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bars are numbered right-to-left so the leftmost bar is white (7).
    function automatic logic [2:0] bar_of(input cnt_t x);
        cnt_t idx;
        idx = x / cnt_t'(BAR_WIDTH);
        return 3'd7 - idx[2:0];
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel/sync bundle between the VGA sync generator (master) and the upstream
// pixel source / DAC side (slave).
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [3:0] PIX_R;
    logic [3:0] PIX_G;
    logic [3:0] PIX_B;
    cnt_t       PIX_X;
    cnt_t       PIX_Y;
    logic       DE;
    logic       PIX_TICK;
    logic       FRAME_START;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;

    modport master (
        input  PIX_R, PIX_G, PIX_B,
        output PIX_X, PIX_Y, DE, PIX_TICK, FRAME_START,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

    modport slave (
        output PIX_R, PIX_G, PIX_B,
        input  PIX_X, PIX_Y, DE, PIX_TICK, FRAME_START,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

endinterface

// File: rtl/vga_pattern_gen.sv
// Eight vertical colour bars, 80 pixels wide, selected from the horizontal counter.
// Only compiled when VGA_TEST_PATTERN_EN is defined.
`ifdef VGA_TEST_PATTERN_EN
module vga_pattern_gen
    import vga_timing_pkg::*;
(
    input  cnt_t    pix_x,
    output rgb444_t rgb
);

    logic [2:0] bar;

    always_comb begin
        bar   = bar_of(pix_x);
        rgb.r = {4{bar[2]}};
        rgb.g = {4{bar[1]}};
        rgb.b = {4{bar[0]}};
    end

endmodule
`endif

// File: rtl/vga_sync_gen.sv
// VGA timing generator: 25 MHz pixel enable from 50 MHz, 10-bit x/y counters,
// registered active-low syncs and blanked colour. VGA_TEST_PATTERN_EN swaps the
// upstream colour for built-in colour bars.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic           MAX10_CLK1_50,
    input  logic           RESET_N,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOT - 1);
    localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    logic    tick_q, tick_d;
    cnt_t    x_q, x_d;
    cnt_t    y_q, y_d;
    logic    hs_q, hs_d;
    logic    vs_q, vs_d;
    rgb444_t rgb_q, rgb_d;

    logic    de;
    logic    x_wrap;
    rgb444_t pix_src;

`ifdef VGA_TEST_PATTERN_EN
    vga_pattern_gen u_pattern (
        .pix_x (x_q),
        .rgb   (pix_src)
    );
`else
    assign pix_src = '{r: vga.PIX_R, g: vga.PIX_G, b: vga.PIX_B};
`endif

    assign de     = (x_q < H_ACT_C) && (y_q < V_ACT_C);
    assign x_wrap = (x_q == H_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        tick_d = ~tick_q;
        x_d    = x_q;
        y_d    = y_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        rgb_d  = rgb_q;
        if (tick_q) begin
            x_d = x_wrap ? '0 : x_q + 1'b1;
            if (x_wrap) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end
            // Syncs and colour describe the coordinate being left, so they
            // trail PIX_X/PIX_Y/DE by exactly one tick.
            hs_d  = !((x_q >= HS_START) && (x_q < HS_END));
            vs_d  = !((y_q >= VS_START) && (y_q < VS_END));
            rgb_d = de ? pix_src : '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= '0;
        end else begin
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
        end
    end

    assign vga.PIX_X       = x_q;
    assign vga.PIX_Y       = y_q;
    assign vga.DE          = de;
    assign vga.PIX_TICK    = tick_q;
    assign vga.FRAME_START = tick_q && (x_q == '0) && (y_q == '0);
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_R       = rgb_q.r;
    assign vga.VGA_G       = rgb_q.g;
    assign vga.VGA_B       = rgb_q.b;

endmodule
